seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
- Reader for the team's 7-segment display interface. Samples a time-multiplexed segment bus: one active-high abcdefg word plus a one-hot digit-enable.
- Waits until each scanned digit has been stable long enough, then decodes the segment pattern back to a BCD digit and keeps a per-digit register bank.
- Used as a display loopback/monitor: verifies what the BCD-to-segment encoders and scan logic actually drive.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (>=1).
- STABLE_CYCLES, 4, consecutive identical samples required before commit (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- abcdefg  input  7  segment levels, bit6=a ... bit0=g, 1 = segment lit.
- dig_en  input  NUM_DIGITS  one-hot digit select; bit i = digit i.
- digits  output  4*NUM_DIGITS  decoded BCD; digit i at [4i+3:4i].
- digit_valid  output  NUM_DIGITS  1 = last committed pattern for digit i was a legal 0-9 glyph.
- bad_pattern  output  NUM_DIGITS  1 = last committed pattern for digit i was neither a legal glyph nor blank.
- update_pulse  output  1  one-cycle strobe on any commit.
- frame_done  output  1  one-cycle strobe when every digit has committed since the previous frame_done.
- scan_err  output  1  one-cycle strobe when a stable sample has non-one-hot dig_en.

Behaviour:
- Reset (rst=1 at an edge): sample register, stability counter, committed flag, seen mask, digits, digit_valid, bad_pattern, update_pulse, frame_done and scan_err all go to 0.
  - A reset mid-stability discards progress. A full STABLE_CYCLES run restarts from the first post-reset sample.
- Input stage: {dig_en, abcdefg} is registered every cycle into S. No combinational path from inputs to outputs.
- Stability counter (width clog2(STABLE_CYCLES+1), saturating):
  - If the new S differs from the previous S, count=1 and committed=0.
  - Otherwise count increments, saturating at STABLE_CYCLES.
- Commit:
  - Occurs on the edge at which count reaches STABLE_CYCLES with committed=0. Then committed=1.
  - Exactly one commit per stable episode. A held input never recommits.
  - Latency: the edge that first captures a new value into S is edge k. Outputs and update_pulse change at edge k+STABLE_CYCLES-1+1, i.e. registered outputs are visible STABLE_CYCLES cycles after S captures.
- Decode table (abcdefg hex -> value):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
- Commit when dig_en is one-hot at bit i:
  - Legal glyph: digits[i]=value, digit_valid[i]=1, bad_pattern[i]=0.
  - 00 (blank): digits[i]=4'hF, digit_valid[i]=0, bad_pattern[i]=0.
  - Any other pattern: digits[i] retains its old value, digit_valid[i]=0, bad_pattern[i]=1.
  - In all three cases update_pulse=1 and seen[i] is set.
- Commit when dig_en is all-zero or multi-hot: no register change, no update_pulse; scan_err=1 for one cycle.
- Glitch handling: a one-cycle change resets the count. Returning to the prior pattern needs a full STABLE_CYCLES again and recommits, producing another update_pulse.
- frame_done:
  - Fires in the same cycle as the update_pulse whose commit makes seen all-ones.
  - Seen clears on that edge, so a new frame starts.
  - Repeated commits of the same digit do not fire frame_done.
- STABLE_CYCLES=1: every change of S commits on the next edge.
- Other digits' registers are never disturbed by a commit to digit i.

Test Plan:
- Reset then basic decode: hold abcdefg=5B, dig_en=0001. digits[3:0]=5, digit_valid=0001 and update_pulse high for one cycle, exactly 4 cycles after S captures. Holding 20 more cycles gives no further pulse.
- Full frame: scan 7E/30/6D/79 on digits 0..3, 8 cycles each. Result: digits=16'h3210, digit_valid=1111, 4 update_pulses, frame_done coincident with the 4th only.
- Glitch rejection: stable 7F on digit 1 for 2 cycles, 1-cycle 00, then 7F held. No commit before 4 stable samples after the glitch; final digits[7:4]=8.
- Illegal and blank: digit 2 legal 9 (7B), then 7F00000-style illegal 0x55. Result: digits[11:8] stays 9, digit_valid[2]=0, bad_pattern[2]=1. Then 0x00 gives digits[11:8]=F, bad_pattern[2]=0.
- Bad select: dig_en=0011 stable with 30. scan_err pulses once, digits/valid unchanged, no update_pulse.
- Reset mid-operation: assert rst after 2 stable cycles of 33 on digit 3, release with input held. All outputs 0 during reset; commit of digits[15:12]=4 occurs 4 cycles after the first post-reset capture.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Display loopback monitor: samples a multiplexed 7-segment bus, waits for each
// scanned digit to settle, and decodes it back into a per-digit BCD register bank.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              abcdefg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   bad_pattern,
    output logic                    update_pulse,
    output logic                    frame_done,
    output logic                    scan_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NUM_DIGITS + 7;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

    logic [SW-1:0]         s_r;
    logic [CW-1:0]         count_r;
    logic                  committed_r;
    logic [NUM_DIGITS-1:0] seen_r;

    logic [SW-1:0]         sample_s;
    logic                  changed_s;
    logic                  commit_s;
    logic [6:0]            seg_s;
    logic [NUM_DIGITS-1:0] sel_s;
    logic                  sel_onehot_s;
    logic [4:0]            glyph_s;
    logic                  blank_s;
    logic [NUM_DIGITS-1:0] seen_next_s;

    // Returns {legal, value}; value is only meaningful when legal is set.
    function automatic logic [4:0] glyph_decode(input logic [6:0] p);
        case (p)
            7'h7E:   glyph_decode = {1'b1, 4'd0};
            7'h30:   glyph_decode = {1'b1, 4'd1};
            7'h6D:   glyph_decode = {1'b1, 4'd2};
            7'h79:   glyph_decode = {1'b1, 4'd3};
            7'h33:   glyph_decode = {1'b1, 4'd4};
            7'h5B:   glyph_decode = {1'b1, 4'd5};
            7'h5F:   glyph_decode = {1'b1, 4'd6};
            7'h70:   glyph_decode = {1'b1, 4'd7};
            7'h7F:   glyph_decode = {1'b1, 4'd8};
            7'h7B:   glyph_decode = {1'b1, 4'd9};
            default: glyph_decode = {1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] x);
        is_onehot = (x != '0) && ((x & (x - NUM_DIGITS'(1))) == '0);
    endfunction

    // Stability/commit qualification and decode of the held sample.
    always_comb begin
        sample_s     = {dig_en, abcdefg};
        changed_s    = (sample_s != s_r);
        commit_s     = (count_r == CMAX) && !committed_r;
        seg_s        = s_r[6:0];
        sel_s        = s_r[SW-1:7];
        sel_onehot_s = is_onehot(sel_s);
        glyph_s      = glyph_decode(seg_s);
        blank_s      = (seg_s == 7'h00);
        seen_next_s  = seen_r | sel_s;
    end

    // Input register, stability counter, commit and output register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r          <= '0;
            count_r      <= '0;
            committed_r  <= 1'b0;
            seen_r       <= '0;
            digits       <= '0;
            digit_valid  <= '0;
            bad_pattern  <= '0;
            update_pulse <= 1'b0;
            frame_done   <= 1'b0;
            scan_err     <= 1'b0;
        end else begin
            s_r          <= sample_s;
            update_pulse <= 1'b0;
            frame_done   <= 1'b0;
            scan_err     <= 1'b0;

            // A new sample restarts the episode even on the edge that commits the old one.
            if (changed_s) begin
                count_r     <= CW'(1);
                committed_r <= 1'b0;
            end else begin
                if (count_r != CMAX) begin
                    count_r <= count_r + CW'(1);
                end
                if (commit_s) begin
                    committed_r <= 1'b1;
                end
            end

            if (commit_s) begin
                if (sel_onehot_s) begin
                    update_pulse <= 1'b1;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (sel_s[i]) begin
                            if (glyph_s[4]) begin
                                digits[4*i +: 4] <= glyph_s[3:0];
                                digit_valid[i]   <= 1'b1;
                                bad_pattern[i]   <= 1'b0;
                            end else if (blank_s) begin
                                digits[4*i +: 4] <= 4'hF;
                                digit_valid[i]   <= 1'b0;
                                bad_pattern[i]   <= 1'b0;
                            end else begin
                                digit_valid[i]   <= 1'b0;
                                bad_pattern[i]   <= 1'b1;
                            end
                        end
                    end
                    if (&seen_next_s) begin
                        frame_done <= 1'b1;
                        seen_r     <= '0;
                    end else begin
                        seen_r     <= seen_next_s;
                    end
                end else begin
                    scan_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed self-checking bench for seg7_scan_reader with default parameters.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  abcdefg;
    logic [3:0]  dig_en;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  bad_pattern;
    logic        update_pulse;
    logic        frame_done;
    logic        scan_err;

    int checks   = 0;
    int failures = 0;
    int up_cnt, fd_cnt, se_cnt, fd_lone, first_pulse, fd_at_pulse, steps;

    seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .abcdefg     (abcdefg),
        .dig_en      (dig_en),
        .digits      (digits),
        .digit_valid (digit_valid),
        .bad_pattern (bad_pattern),
        .update_pulse(update_pulse),
        .frame_done  (frame_done),
        .scan_err    (scan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        up_cnt = 0; fd_cnt = 0; se_cnt = 0; fd_lone = 0;
        first_pulse = -1; fd_at_pulse = -1; steps = 0;
    endtask

    // Advance n cycles, sampling strobes 1 time unit after each rising edge.
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            steps++;
            if (update_pulse === 1'b1) begin
                up_cnt++;
                if (first_pulse < 0) first_pulse = steps;
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_at_pulse = up_cnt;
                if (update_pulse !== 1'b1) fd_lone++;
            end
            if (scan_err === 1'b1) se_cnt++;
        end
    endtask

    task automatic drive(input logic [6:0] seg, input logic [3:0] en);
        abcdefg = seg;
        dig_en  = en;
    endtask

    initial begin
        rst = 1'b1;
        drive(7'h00, 4'b0000);
        clr_counts();
        hold(2);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_bad", 32'(bad_pattern), 32'h0);
        chk("rst_strobes", {29'd0, update_pulse, frame_done, scan_err}, 32'h0);

        // Basic decode: 5 on digit 0, first capture on the release edge.
        rst = 1'b0;
        drive(7'h5B, 4'b0001);
        clr_counts();
        hold(4);
        chk("basic_no_early", 32'(up_cnt), 32'd0);
        hold(1);
        chk("basic_pulse", 32'(update_pulse), 32'd1);
        chk("basic_digit", 32'(digits[3:0]), 32'd5);
        chk("basic_valid", 32'(digit_valid), 32'b0001);
        hold(20);
        chk("basic_single", 32'(up_cnt), 32'd1);
        chk("basic_first", 32'(first_pulse), 32'd5);

        // Full frame 0,1,2,3 across the four positions.
        clr_counts();
        drive(7'h7E, 4'b0001); hold(8);
        drive(7'h30, 4'b0010); hold(8);
        drive(7'h6D, 4'b0100); hold(8);
        drive(7'h79, 4'b1000); hold(8);
        chk("frame_digits", 32'(digits), 32'h3210);
        chk("frame_valid", 32'(digit_valid), 32'b1111);
        chk("frame_pulses", 32'(up_cnt), 32'd4);
        chk("frame_done_cnt", 32'(fd_cnt), 32'd1);
        chk("frame_done_at4", 32'(fd_at_pulse), 32'd4);
        chk("frame_done_lone", 32'(fd_lone), 32'd0);

        // Glitch: 2 cycles of 8, one blank cycle, then 8 held.
        clr_counts();
        drive(7'h7F, 4'b0010); hold(2);
        drive(7'h00, 4'b0010); hold(1);
        drive(7'h7F, 4'b0010); hold(4);
        chk("glitch_no_early", 32'(up_cnt), 32'd0);
        chk("glitch_digit_old", 32'(digits[7:4]), 32'd1);
        hold(1);
        chk("glitch_pulse", 32'(update_pulse), 32'd1);
        chk("glitch_digit", 32'(digits[7:4]), 32'd8);

        // Legal 9, then illegal 0x55, then blank on digit 2.
        drive(7'h7B, 4'b0100); hold(8);
        chk("legal9_digit", 32'(digits[11:8]), 32'd9);
        chk("legal9_valid", 32'(digit_valid[2]), 32'd1);
        clr_counts();
        drive(7'h55, 4'b0100); hold(8);
        chk("illegal_digit", 32'(digits[11:8]), 32'd9);
        chk("illegal_valid", 32'(digit_valid[2]), 32'd0);
        chk("illegal_bad", 32'(bad_pattern[2]), 32'd1);
        chk("illegal_pulse", 32'(up_cnt), 32'd1);
        drive(7'h00, 4'b0100); hold(8);
        chk("blank_digit", 32'(digits[11:8]), 32'hF);
        chk("blank_bad", 32'(bad_pattern[2]), 32'd0);
        chk("blank_valid", 32'(digit_valid[2]), 32'd0);
        chk("no_frame_yet", 32'(fd_cnt), 32'd0);

        // Multi-hot select must not touch the register bank.
        clr_counts();
        drive(7'h30, 4'b0011); hold(8);
        chk("badsel_err", 32'(se_cnt), 32'd1);
        chk("badsel_pulse", 32'(up_cnt), 32'd0);
        chk("badsel_digits", 32'(digits), 32'h3F80);
        chk("badsel_valid", 32'(digit_valid), 32'b1011);
        chk("badsel_bad", 32'(bad_pattern), 32'b0000);

        // Reset part-way through a stable episode on digit 3.
        clr_counts();
        drive(7'h33, 4'b1000); hold(2);
        rst = 1'b1;
        hold(2);
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_flags", {24'd0, digit_valid, bad_pattern}, 32'h0);
        chk("midrst_strobes", {29'd0, update_pulse, frame_done, scan_err}, 32'h0);
        rst = 1'b0;
        clr_counts();
        hold(4);
        chk("midrst_no_early", 32'(up_cnt), 32'd0);
        hold(1);
        chk("midrst_pulse", 32'(update_pulse), 32'd1);
        chk("midrst_digit", 32'(digits), 32'h4000);
        chk("midrst_valid", 32'(digit_valid), 32'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
